// File: rtl/cordic_input_sequencer_if.sv
// cordic_input_sequencer_if
// Request handshake, core operand outputs and result/credit signals of the
// CORDIC input sequencer. The master side drives requests and returns
// credits. The slave side is the sequencer itself.
interface cordic_input_sequencer_if #(
  parameter int WIDTH = 16
);
  // Request channel (valid/ready)
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;

  // Operand set presented to the CORDIC core
  logic             mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             issue_valid;

  // Result tracking and credit return
  logic             res_valid;
  logic             res_folded;
  logic             res_pop;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, res_pop,
    input  in_ready, mode, x, y, z, issue_valid, res_valid, res_folded
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, res_pop,
    output in_ready, mode, x, y, z, issue_valid, res_valid, res_folded
  );
endinterface

// File: rtl/cordic_input_sequencer.sv
// cordic_input_sequencer
// Feeds a 16-bit, 8-stage CORDIC core. Requests pass through a 2-entry FIFO
// and are quadrant-folded when they are written. At most one operand set is
// issued per cycle, and each issue needs a credit from the downstream result
// buffer. A LATENCY-deep valid/tag pipeline marks the cycle in which each
// result leaves the core.
// Optional feature macro: CORDIC_QUAD_FOLD_EN enables quadrant pre-folding.
// When the macro is undefined, operands pass through and folded is always 0.
module cordic_input_sequencer #(
  parameter int               WIDTH   = 16,
  parameter int               LATENCY = 8,   // must be >= 2
  parameter int               CREDITS = 4,
  parameter logic [WIDTH-1:0] PI      = 16'h6488,
  parameter logic [WIDTH-1:0] HALF_PI = 16'h3244
) (
  input logic                     clk,
  input logic                     reset,   // asynchronous, active low
  cordic_input_sequencer_if.slave bus
);

  localparam int            CW          = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             folded;
  } entry_t;

  entry_t           w_wr_entry;
  entry_t           w_head;
  logic             w_in_ready;
  logic             w_push;
  logic             w_issue;

  entry_t           r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [CW-1:0]    r_credits;

  logic             r_mode;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic             r_folded;
  logic             r_issue_valid;
  logic [LATENCY-1:0] r_vld_pipe;
  logic [LATENCY-1:0] r_fold_pipe;

`ifdef CORDIC_QUAD_FOLD_EN
  localparam logic [WIDTH-1:0]        S_MIN         = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] S_HALF_PI     = HALF_PI;
  localparam logic signed [WIDTH-1:0] S_NEG_HALF_PI = -HALF_PI;

  // Two's-complement negation that maps the most negative value to the most
  // positive one instead of wrapping back to itself.
  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    return (v == S_MIN) ? ~S_MIN : (~v + 1'b1);
  endfunction

  // Move the request into the core's convergence range before it is buffered.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_wr_entry = '{mode: bus.in_mode, x: bus.in_x, y: bus.in_y, z: bus.in_z, folded: 1'b0};
    if (bus.in_mode) begin
      if ($signed(bus.in_z) > S_HALF_PI) begin
        w_wr_entry.x      = sat_neg(bus.in_x);
        w_wr_entry.y      = sat_neg(bus.in_y);
        w_wr_entry.z      = bus.in_z - PI;
        w_wr_entry.folded = 1'b1;
      end else if ($signed(bus.in_z) < S_NEG_HALF_PI) begin
        w_wr_entry.x      = sat_neg(bus.in_x);
        w_wr_entry.y      = sat_neg(bus.in_y);
        w_wr_entry.z      = bus.in_z + PI;
        w_wr_entry.folded = 1'b1;
      end
    end else if (bus.in_x[WIDTH-1]) begin
      w_wr_entry.x      = sat_neg(bus.in_x);
      w_wr_entry.y      = sat_neg(bus.in_y);
      w_wr_entry.z      = bus.in_y[WIDTH-1] ? (bus.in_z - PI) : (bus.in_z + PI);
      w_wr_entry.folded = 1'b1;
    end
  end
`else
  // Folding disabled: the angle constants are only needed by the fold path.
  logic w_unused_fold_consts;
  assign w_unused_fold_consts = ^{PI, HALF_PI};

  // Pass the request through unchanged.
  always_comb begin
    w_wr_entry = '{mode: bus.in_mode, x: bus.in_x, y: bus.in_y, z: bus.in_z, folded: 1'b0};
  end
`endif

  assign w_in_ready = (r_count != 2'd2);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_issue    = (r_count != 2'd0) && (r_credits != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // FIFO storage: data is qualified by r_count, so it needs no reset.
  // NOTE: the memory array is deliberately left unreset; clearing the pointers and count is enough and keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // FIFO pointers and occupancy; a push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push)  r_wr_ptr <= ~r_wr_ptr;
      if (w_issue) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit counter: an issue takes a credit and res_pop returns one. A return
  // with every credit already home is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= CREDITS_MAX;
    end else if (w_issue && !bus.res_pop) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_issue && bus.res_pop && (r_credits != CREDITS_MAX)) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  // Core operand registers: load from the FIFO head on issue, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_folded      <= 1'b0;
      r_issue_valid <= 1'b0;
    end else begin
      r_issue_valid <= w_issue;
      if (w_issue) begin
        r_mode   <= w_head.mode;
        r_x      <= w_head.x;
        r_y      <= w_head.y;
        r_z      <= w_head.z;
        r_folded <= w_head.folded;
      end
    end
  end

  // Valid/tag pipeline that tracks each issued operand set through the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe  <= '0;
      r_fold_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[LATENCY-2:0], r_issue_valid};
      r_fold_pipe <= {r_fold_pipe[LATENCY-2:0], r_issue_valid & r_folded};
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.mode        = r_mode;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.z           = r_z;
  assign bus.issue_valid = r_issue_valid;
  assign bus.res_valid   = r_vld_pipe[LATENCY-1];
  assign bus.res_folded  = r_fold_pipe[LATENCY-1];

endmodule

// File: tb/tb_cordic_input_sequencer.sv
// tb_cordic_input_sequencer
// Directed bench for cordic_input_sequencer. It uses a 4-credit instance for
// the fold table, FIFO-full, reset and credit-overflow cases, and a 2-credit
// instance for the credit stall. Expected fold results follow the
// CORDIC_QUAD_FOLD_EN macro.
module tb_cordic_input_sequencer;

`ifdef CORDIC_QUAD_FOLD_EN
  localparam bit FOLD_EN = 1'b1;
`else
  localparam bit FOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_input_sequencer_if #(.WIDTH(16)) bus4 ();
  cordic_input_sequencer_if #(.WIDTH(16)) bus2 ();

  cordic_input_sequencer #(.CREDITS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  cordic_input_sequencer #(.CREDITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic        mode;
    logic [15:0] x, y, z;
    logic [15:0] ex, ey, ez;   // expected values with folding enabled
    logic        ef;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  // Pulse counters sampled 2 time units after each rising edge
  int n_issue4 = 0, n_res4 = 0, n_issue2 = 0, n_res2 = 0;
  always begin
    @(posedge clk);
    #2;
    if (bus4.issue_valid) n_issue4++;
    if (bus4.res_valid)   n_res4++;
    if (bus2.issue_valid) n_issue2++;
    if (bus2.res_valid)   n_res2++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic m, input logic [15:0] x, y, z,
                              input logic [15:0] ex, ey, ez, input logic ef);
    vec_t v;
    v.mode = m; v.x = x; v.y = y; v.z = z;
    v.ex = ex; v.ey = ey; v.ez = ez; v.ef = ef;
    return v;
  endfunction

  // Present a request to the 4-credit instance and hold it until it is accepted.
  // Returns on the falling edge after the accepting rising edge.
  task automatic drive_req4(input logic m, input logic [15:0] xx, input logic [15:0] yy,
                            input logic [15:0] zz);
    int n;
    bus4.in_valid = 1'b1;
    bus4.in_mode  = m;
    bus4.in_x     = xx;
    bus4.in_y     = yy;
    bus4.in_z     = zz;
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req4_accept_in_time", 32'(n < 20), 32'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   c_iss, c_res;

    vecs[0]  = mk(1'b1, 16'h1000, 16'h0000, 16'h4000, 16'hF000, 16'h0000, 16'hDB78, 1'b1);
    vecs[1]  = mk(1'b0, 16'hF000, 16'h0800, 16'h0000, 16'h1000, 16'hF800, 16'h6488, 1'b1);
    vecs[2]  = mk(1'b0, 16'h0400, 16'h0800, 16'h0000, 16'h0400, 16'h0800, 16'h0000, 1'b0);
    vecs[3]  = mk(1'b1, 16'h8000, 16'h8000, 16'hA000, 16'h7FFF, 16'h7FFF, 16'h0488, 1'b1);
    vecs[4]  = mk(1'b1, 16'h1234, 16'h5678, 16'h3244, 16'h1234, 16'h5678, 16'h3244, 1'b0);
    vecs[5]  = mk(1'b1, 16'h1234, 16'h5678, 16'hCDBC, 16'h1234, 16'h5678, 16'hCDBC, 1'b0);
    vecs[6]  = mk(1'b1, 16'h0100, 16'hFF00, 16'h3245, 16'hFF00, 16'h0100, 16'hCDBD, 1'b1);
    vecs[7]  = mk(1'b0, 16'h8000, 16'hFF00, 16'h1000, 16'h7FFF, 16'h0100, 16'hAB78, 1'b1);
    vecs[8]  = mk(1'b0, 16'h0000, 16'h8000, 16'h1111, 16'h0000, 16'h8000, 16'h1111, 1'b0);
    vecs[9]  = mk(1'b0, 16'hC000, 16'h0000, 16'h7000, 16'h4000, 16'h0000, 16'hD488, 1'b1);
    vecs[10] = mk(1'b1, 16'h7FFF, 16'h0001, 16'hCDBB, 16'h8001, 16'hFFFF, 16'h3243, 1'b1);

    bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.res_pop = 1'b0;
    bus4.in_x = '0; bus4.in_y = '0; bus4.in_z = '0;
    bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.res_pop = 1'b0;
    bus2.in_x = '0; bus2.in_y = '0; bus2.in_z = '0;

    // ---------------- reset state ----------------
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mode",        32'(bus4.mode),        32'd0);
    check("rst_x",           32'(bus4.x),           32'd0);
    check("rst_y",           32'(bus4.y),           32'd0);
    check("rst_z",           32'(bus4.z),           32'd0);
    check("rst_issue_valid", 32'(bus4.issue_valid), 32'd0);
    check("rst_res_valid",   32'(bus4.res_valid),   32'd0);
    check("rst_res_folded",  32'(bus4.res_folded),  32'd0);
    check("rst_in_ready",    32'(bus4.in_ready),    32'd1);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- fold table: issue timing and result latency ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive_req4(v.mode, v.x, v.y, v.z);
      check($sformatf("v%0d_no_issue_on_accept", i), 32'(bus4.issue_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_issue_valid", i), 32'(bus4.issue_valid), 32'd1);
      check($sformatf("v%0d_mode", i), 32'(bus4.mode), 32'(v.mode));
      check($sformatf("v%0d_x", i), 32'(bus4.x), 32'(FOLD_EN ? v.ex : v.x));
      check($sformatf("v%0d_y", i), 32'(bus4.y), 32'(FOLD_EN ? v.ey : v.y));
      check($sformatf("v%0d_z", i), 32'(bus4.z), 32'(FOLD_EN ? v.ez : v.z));
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) check($sformatf("v%0d_issue_pulse_ends", i), 32'(bus4.issue_valid), 32'd0);
        if (k == 7) check($sformatf("v%0d_res_not_early", i), 32'(bus4.res_valid), 32'd0);
      end
      check($sformatf("v%0d_res_valid", i), 32'(bus4.res_valid), 32'd1);
      check($sformatf("v%0d_res_folded", i), 32'(bus4.res_folded), 32'(FOLD_EN ? v.ef : 1'b0));
      bus4.res_pop = 1'b1;
      @(negedge clk);
      bus4.res_pop = 1'b0;
    end

    // ---------------- credit stall on the 2-credit instance ----------------
    c_iss = n_issue2;
    c_res = n_res2;
    for (int i = 0; i < 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_mode  = 1'b1;
      bus2.in_x     = 16'h0A00 + 16'(i);
      bus2.in_y     = 16'h0000;
      bus2.in_z     = 16'h0100;
      check($sformatf("c2_ready_push%0d", i), 32'(bus2.in_ready), 32'd1);
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("c2_issue_count",      32'(n_issue2 - c_iss), 32'd2);
    check("c2_res_count",        32'(n_res2 - c_res),   32'd2);
    check("c2_third_held_ready", 32'(bus2.in_ready),    32'd1);
    bus2.res_pop = 1'b1;
    @(negedge clk);
    bus2.res_pop = 1'b0;
    check("c2_no_issue_on_pop_edge", 32'(bus2.issue_valid), 32'd0);
    @(negedge clk);
    check("c2_third_issue", 32'(bus2.issue_valid), 32'd1);
    check("c2_third_x",     32'(bus2.x),           32'h0A02);
    repeat (7) @(negedge clk);
    check("c2_third_res_not_early", 32'(bus2.res_valid), 32'd0);
    @(negedge clk);
    check("c2_third_res_valid", 32'(bus2.res_valid), 32'd1);

    // ---------------- FIFO full with credits exhausted ----------------
    for (int i = 0; i < 4; i++) drive_req4(1'b1, 16'h0F00 + 16'(i), 16'h0000, 16'h0000);
    drive_req4(1'b1, 16'h0D05, 16'h0000, 16'h0000);
    drive_req4(1'b1, 16'h0D06, 16'h0000, 16'h0000);
    check("full_ready_low", 32'(bus4.in_ready), 32'd0);
    bus4.in_valid = 1'b1;
    bus4.in_x     = 16'h0D07;
    repeat (3) @(negedge clk);
    bus4.in_valid = 1'b0;
    check("full_ready_still_low", 32'(bus4.in_ready), 32'd0);
    bus4.res_pop = 1'b1;
    @(negedge clk);
    bus4.res_pop = 1'b0;
    check("full_pop_edge_ready", 32'(bus4.in_ready),    32'd0);
    check("full_pop_edge_issue", 32'(bus4.issue_valid), 32'd0);
    @(negedge clk);
    check("full_head_issue",      32'(bus4.issue_valid), 32'd1);
    check("full_head_x",          32'(bus4.x),           32'h0D05);
    check("full_ready_after_pop", 32'(bus4.in_ready),    32'd1);
    bus4.res_pop = 1'b1;
    @(negedge clk);
    bus4.res_pop = 1'b0;
    @(negedge clk);
    check("full_second_issue", 32'(bus4.issue_valid), 32'd1);
    check("full_second_x",     32'(bus4.x),           32'h0D06);
    bus4.res_pop = 1'b1;
    @(negedge clk);
    bus4.res_pop = 1'b0;
    c_iss = n_issue4;
    repeat (4) @(negedge clk);
    check("full_third_not_captured", 32'(n_issue4 - c_iss), 32'd0);

    // ---------------- reset mid-operation ----------------
    bus4.res_pop = 1'b1;
    repeat (4) @(negedge clk);
    bus4.res_pop = 1'b0;
    for (int i = 0; i < 3; i++) drive_req4(1'b1, 16'h0E00 + 16'(i), 16'h0011, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_x",           32'(bus4.x),           32'd0);
    check("mid_rst_y",           32'(bus4.y),           32'd0);
    check("mid_rst_z",           32'(bus4.z),           32'd0);
    check("mid_rst_mode",        32'(bus4.mode),        32'd0);
    check("mid_rst_issue_valid", 32'(bus4.issue_valid), 32'd0);
    check("mid_rst_res_valid",   32'(bus4.res_valid),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_ready", 32'(bus4.in_ready), 32'd1);
    c_res = n_res4;
    c_iss = n_issue4;
    repeat (20) @(negedge clk);
    check("mid_rst_no_res_after", 32'(n_res4 - c_res),   32'd0);
    check("mid_rst_no_issue",     32'(n_issue4 - c_iss), 32'd0);

    // ---------------- credit return at full count is ignored ----------------
    bus4.res_pop = 1'b1;
    repeat (3) @(negedge clk);
    bus4.res_pop = 1'b0;
    c_iss = n_issue4;
    for (int i = 0; i < 6; i++) drive_req4(1'b1, 16'h0B00 + 16'(i), 16'h0000, 16'h0000);
    repeat (12) @(negedge clk);
    check("ovf_issue_count", 32'(n_issue4 - c_iss), 32'd4);
    check("ovf_fifo_full",   32'(bus4.in_ready),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_input_sequencer.md
Name: cordic_input_sequencer

Overview:
- Upstream feeder for the 16-bit, 8-stage CORDIC core.
- Accepts operand requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Performs quadrant pre-folding so operands fall inside the core's convergence range, then issues one operand set per cycle to the core's mode/x/y/z inputs.
- Issue is credit-gated against a downstream result buffer. A latency-matched valid/tag pipeline marks when core results (res1/res2) are valid.

Parameters:
- WIDTH, 16, operand width (signed two's complement).
- LATENCY, 8, cycles from operands visible at core inputs to results valid.
- CREDITS, 4, result slots available downstream.
- PI, 16'h6488, pi in Q2.13 radians.
- HALF_PI, 16'h3244, pi/2 in Q2.13 radians.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_mode  in  1  1 = rotation, 0 = vectoring.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- in_z  in  WIDTH  operand z (angle, Q2.13).
- mode  out  1  to core.
- x  out  WIDTH  to core.
- y  out  WIDTH  to core.
- z  out  WIDTH  to core.
- issue_valid  out  1  core inputs hold a new operand set this cycle.
- res_valid  out  1  core results valid this cycle.
- res_folded  out  1  fold flag of the operand whose result is now valid.
- res_pop  in  1  downstream consumed one result; returns one credit.

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, credits=CREDITS, valid/tag pipeline cleared. Outputs: mode=0, x=y=z=0, issue_valid=0, res_valid=0, res_folded=0. in_ready=1 once the FIFO is empty.
- in_ready = FIFO not full (combinational, no bypass). When full, in_valid is ignored and the inputs are not captured.
- Fold is applied at FIFO write; the stored entry is {mode, x, y, z, folded}.
  - Rotation, z > HALF_PI: z -= PI, x = -x, y = -y, folded=1.
  - Rotation, z < -HALF_PI: z += PI, x = -x, y = -y, folded=1.
  - Rotation, |z| <= HALF_PI: unchanged, folded=0.
  - Vectoring, x < 0: x = -x, y = -y; z += PI if y >= 0 (original y), else z -= PI; folded=1.
  - Vectoring, x >= 0: unchanged, folded=0.
- Negation saturates: -(16'h8000) = 16'h7FFF.
- Angle add/sub wraps modulo 2^WIDTH; no saturation.
- Issue condition: FIFO non-empty && credits > 0. On an issue edge:
  - x/y/z/mode are registered from the FIFO head.
  - issue_valid=1 for that cycle.
  - The head is popped and credits are decremented.
- Without an issue, x/y/z/mode hold their values and issue_valid=0.
- Minimum latency: accepted at edge N → issue_valid high after edge N+1.
- Push and pop in the same cycle are allowed when the FIFO is not full.
- Valid/tag pipeline: LATENCY-deep shift register of {issue_valid, folded}. res_valid and res_folded assert exactly LATENCY cycles after the corresponding issue_valid.
- Credits:
  - Issue and res_pop in the same cycle → count unchanged.
  - res_pop when credits == CREDITS is ignored (no overflow).
  - Credits never go negative.
- Reset mid-operation: all buffered and in-flight operations are discarded; no res_valid appears for them after reset release.
- Back-to-back issue at 1 per cycle is sustained while credits and FIFO data are available.

Optional Feature:
- CORDIC_QUAD_FOLD_EN
  - Defined: folding as above.
  - Undefined: operands pass through unmodified, folded is always 0, and the fold arithmetic is not synthesized.
  - All handshake, credit and latency behaviour is identical in both builds.

Test Plan:
1. Rotation fold (macro defined): mode=1, x=16'h1000, y=16'h0000, z=16'h4000 → one cycle after acceptance: x=16'hF000, y=16'h0000, z=16'hDB78, issue_valid=1. Eight cycles later: res_valid=1, res_folded=1.
2. Vectoring fold: mode=0, x=16'hF000, y=16'h0800, z=16'h0000 → x=16'h1000, y=16'hF800, z=16'h6488, folded=1. Repeat with x=16'h0400 → passes unchanged, folded=0.
3. Saturation: rotation, x=16'h8000, y=16'h8000, z=16'hA000 → x=y=16'h7FFF, z=16'h0488.
4. Credit stall (CREDITS=2): push 3 requests, no res_pop → exactly 2 issue_valid pulses and the third stays buffered. Pulse res_pop → third issues on the next edge, and res_valid for it follows 8 cycles later.
5. FIFO full: hold the 4-credit block at 0 credits, push 2 entries → in_ready=0. A third in_valid is not captured. One res_pop → in_ready returns to 1 the cycle after the head issues.
6. Reset mid-operation: issue 3 operands, assert reset 3 cycles later for one cycle → all outputs zero immediately, in_ready=1 after release, and no res_valid occurs afterwards.
